// File: rtl/weapon_attack_ctrl_pkg.sv
// Shared types and constants for the weapon attack sequencer and the weapon draw stage.
package weapon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MELEE    = 2'd1,
    ST_ARCHER   = 2'd2,
    ST_COOLDOWN = 2'd3
  } weapon_atk_state_t;

  localparam logic [1:0] CLASS_MELEE  = 2'b01;
  localparam logic [1:0] CLASS_ARCHER = 2'b10;

  // Colour keys the draw stage treats as "no pixel" in weapon sprites.
  localparam logic [11:0] TRANSPARENT     = 12'hF0F;
  localparam logic [23:0] TRANSPARENT_RGB = 24'hFF00FF;

endpackage

// File: rtl/weapon_attack_ctrl_frame_timer.sv
// 8-bit loadable frame down-counter; shared by the swing/draw phase and the cooldown lockout.
module frame_timer
  import weapon_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] count,
  output logic       done
);

  logic [7:0] count_q, count_d;

  // A load in the same cycle as a tick wins, so the entry frame is never counted.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (tick && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign done  = (count_q == 8'd0);

endmodule

// File: rtl/weapon_attack_ctrl.sv
// One weapon attack per click: melee swing with single damage strobe, or archer draw with arrow release.
module weapon_attack_ctrl
  import weapon_pkg::*;
#(
  parameter int unsigned SWING_FRAMES    = 8,
  parameter int unsigned SWING_STEP      = 3,
  parameter int unsigned DRAW_FRAMES     = 12,
  parameter int unsigned MELEE_COOLDOWN  = 20,
  parameter int unsigned ARCHER_COOLDOWN = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        mouse_left,
  input  logic [1:0]  game_active,
  input  logic [1:0]  char_class,
  input  logic        melee_hit_raw,
  output logic        attack_active,
  output logic [11:0] anim_x_offset,
  output logic [1:0]  atk_class,
  output logic        damage_pulse,
  output logic        arrow_fire,
  output logic        busy
);

  weapon_atk_state_t state_q, state_d;
  logic        mouse_q;
  logic [1:0]  atk_class_q, atk_class_d;
  logic [11:0] anim_q, anim_d;
  logic        damage_q, damage_d;
  logic        hit_done_q, hit_done_d;
  logic        arrow_d;
  logic        tmr_load;
  logic [7:0]  tmr_val;
  logic [7:0]  tmr_count;
  logic        tmr_done;
  logic        start_req;
  logic        game_on;
  logic        phase_end;

  frame_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .tick     (frame_tick),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_count),
    .done     (tmr_done)
  );

  assign start_req = mouse_left & ~mouse_q;
  assign game_on   = |game_active;
  // The phase ends on the frame tick that consumes its last frame, not one cycle later.
  assign phase_end = tmr_done | (frame_tick & (tmr_count == 8'd1));

  always_comb begin
    state_d     = state_q;
    atk_class_d = atk_class_q;
    anim_d      = anim_q;
    damage_d    = 1'b0;
    hit_done_d  = hit_done_q;
    arrow_d     = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = 8'd0;
    if (!game_on) begin
      state_d    = ST_IDLE;
      anim_d     = 12'd0;
      hit_done_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          anim_d     = 12'd0;
          hit_done_d = 1'b0;
          if (start_req && (char_class == CLASS_MELEE)) begin
            state_d     = ST_MELEE;
            atk_class_d = char_class;
            tmr_load    = 1'b1;
            tmr_val     = 8'(SWING_FRAMES);
          end else if (start_req && (char_class == CLASS_ARCHER)) begin
            state_d     = ST_ARCHER;
            atk_class_d = char_class;
            tmr_load    = 1'b1;
            tmr_val     = 8'(DRAW_FRAMES);
          end
        end
        ST_MELEE: begin
          if (melee_hit_raw && !hit_done_q) begin
            damage_d   = 1'b1;
            hit_done_d = 1'b1;
          end
          if (phase_end) begin
            state_d    = ST_COOLDOWN;
            anim_d     = 12'd0;
            hit_done_d = 1'b0;
            tmr_load   = 1'b1;
            tmr_val    = 8'(MELEE_COOLDOWN);
          end else if (frame_tick) begin
            anim_d = anim_q + 12'(SWING_STEP);
          end
        end
        ST_ARCHER: begin
          anim_d = 12'd0;
          if (phase_end) begin
            arrow_d  = 1'b1;
            state_d  = ST_COOLDOWN;
            tmr_load = 1'b1;
            tmr_val  = 8'(ARCHER_COOLDOWN);
          end
        end
        ST_COOLDOWN: begin
          anim_d = 12'd0;
          if (phase_end) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          anim_d  = 12'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      mouse_q     <= 1'b0;
      atk_class_q <= 2'b00;
      anim_q      <= 12'd0;
      damage_q    <= 1'b0;
      hit_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mouse_q     <= mouse_left;
      atk_class_q <= atk_class_d;
      anim_q      <= anim_d;
      damage_q    <= damage_d;
      hit_done_q  <= hit_done_d;
    end
  end

  assign attack_active = (state_q == ST_MELEE) || (state_q == ST_ARCHER);
  assign busy          = (state_q != ST_IDLE);
  assign anim_x_offset = anim_q;
  assign atk_class     = atk_class_q;
  assign damage_pulse  = damage_q;
  assign arrow_fire    = arrow_d;

endmodule

// File: tb/tb_weapon_attack_ctrl.sv
// Directed and randomized checks of weapon_attack_ctrl against a frame-level behavioural model.
module tb_weapon_attack_ctrl;

  localparam int SWING_FRAMES    = 8;
  localparam int SWING_STEP      = 3;
  localparam int DRAW_FRAMES     = 12;
  localparam int MELEE_COOLDOWN  = 20;
  localparam int ARCHER_COOLDOWN = 30;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        frame_tick;
  logic        mouse_left;
  logic [1:0]  game_active;
  logic [1:0]  char_class;
  logic        melee_hit_raw;
  logic        attack_active;
  logic [11:0] anim_x_offset;
  logic [1:0]  atk_class;
  logic        damage_pulse;
  logic        arrow_fire;
  logic        busy;

  weapon_attack_ctrl #(
    .SWING_FRAMES    (SWING_FRAMES),
    .SWING_STEP      (SWING_STEP),
    .DRAW_FRAMES     (DRAW_FRAMES),
    .MELEE_COOLDOWN  (MELEE_COOLDOWN),
    .ARCHER_COOLDOWN (ARCHER_COOLDOWN)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .mouse_left    (mouse_left),
    .game_active   (game_active),
    .char_class    (char_class),
    .melee_hit_raw (melee_hit_raw),
    .attack_active (attack_active),
    .anim_x_offset (anim_x_offset),
    .atk_class     (atk_class),
    .damage_pulse  (damage_pulse),
    .arrow_fire    (arrow_fire),
    .busy          (busy)
  );

  int tests_run = 0;
  int failed    = 0;

  // stimulus knobs
  int frame_cnt = 2;
  int gap_lo = 3;
  int gap_hi = 8;
  bit hit_rand = 1'b0;

  // observation counters
  int dmg_seen, arrow_seen, starts_seen;
  logic busy_prev = 1'b0;

  // behavioural model: phase 0 idle, 1 swinging, 2 drawing bow, 3 locked out
  int       m_mode, m_frames, m_cool;
  bit       m_prev, m_hit_done, m_dmg;
  logic [1:0] m_cls;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_frames = 0; m_cool = 0;
    m_prev = 1'b0; m_hit_done = 1'b0; m_dmg = 1'b0; m_cls = 2'b00;
  endtask

  task automatic model_step();
    bit req;
    if (!rst) begin
      model_reset();
      return;
    end
    req = mouse_left && !m_prev;
    m_prev = mouse_left;
    if (game_active == 2'b00) begin
      m_mode = 0; m_dmg = 1'b0; m_hit_done = 1'b0;
      return;
    end
    m_dmg = 1'b0;
    case (m_mode)
      0: begin
        if (req && (char_class == 2'b01 || char_class == 2'b10)) begin
          m_mode = (char_class == 2'b01) ? 1 : 2;
          m_frames = 0; m_cls = char_class; m_hit_done = 1'b0;
        end
      end
      1: begin
        if (melee_hit_raw && !m_hit_done) begin m_dmg = 1'b1; m_hit_done = 1'b1; end
        if (frame_tick) m_frames++;
        if (m_frames == SWING_FRAMES) begin
          m_mode = 3; m_cool = MELEE_COOLDOWN; m_hit_done = 1'b0;
        end
      end
      2: begin
        if (frame_tick) m_frames++;
        if (m_frames == DRAW_FRAMES) begin m_mode = 3; m_cool = ARCHER_COOLDOWN; end
      end
      default: begin
        if (frame_tick) m_cool--;
        if (m_cool == 0) m_mode = 0;
      end
    endcase
  endtask

  task automatic check_outputs();
    bit exp_arrow;
    exp_arrow = (m_mode == 2) && frame_tick && (m_frames == DRAW_FRAMES - 1) && (game_active != 2'b00);
    chk("attack_active", 32'(attack_active), 32'(m_mode == 1 || m_mode == 2));
    chk("busy", 32'(busy), 32'(m_mode != 0));
    chk("anim_x_offset", 32'(anim_x_offset), (m_mode == 1) ? 32'(m_frames * SWING_STEP) : 32'd0);
    chk("atk_class", 32'(atk_class), 32'(m_cls));
    chk("damage_pulse", 32'(damage_pulse), 32'(m_dmg));
    chk("arrow_fire", 32'(arrow_fire), 32'(exp_arrow));
  endtask

  // One clock: inputs already driven at posedge+1, outputs checked at negedge, model advanced at posedge.
  task automatic cycle();
    if (frame_cnt == 0) begin
      frame_tick = 1'b1;
      frame_cnt = $urandom_range(gap_hi, gap_lo);
    end else begin
      frame_tick = 1'b0;
      frame_cnt--;
    end
    if (hit_rand) melee_hit_raw = ($urandom_range(3, 0) == 0);
    @(negedge clk);
    check_outputs();
    if (damage_pulse === 1'b1) dmg_seen++;
    if (arrow_fire === 1'b1) arrow_seen++;
    if (busy === 1'b1 && busy_prev === 1'b0) starts_seen++;
    busy_prev = busy;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wait_until(input int mode, input int frames, input string tag);
    int n = 0;
    while (!(m_mode == mode && (frames < 0 || m_frames == frames)) && n < 5000) begin
      cycle();
      n++;
    end
    chk(tag, 32'(n < 5000), 32'd1);
  endtask

  task automatic press();
    mouse_left = 1'b1;
    cycle();
    mouse_left = 1'b0;
    cycle();
  endtask

  initial begin
    rst = 1'b0;
    frame_tick = 1'b0; mouse_left = 1'b0; game_active = 2'b00;
    char_class = 2'b00; melee_hit_raw = 1'b0;
    model_reset();
    #2;
    chk("rst_attack_active", 32'(attack_active), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_anim", 32'(anim_x_offset), 32'd0);
    chk("rst_damage", 32'(damage_pulse), 32'd0);
    chk("rst_arrow", 32'(arrow_fire), 32'd0);
    chk("rst_class", 32'(atk_class), 32'd0);
    @(posedge clk); #1;
    cycle();
    rst = 1'b1;
    cycle();

    // melee swing, no overlap
    game_active = 2'b01; char_class = 2'b01;
    dmg_seen = 0;
    press();
    wait_until(0, -1, "melee_done_timeout");
    chk("melee_no_hit_dmg", 32'(dmg_seen), 32'd0);

    // melee with overlap bursts in frames 2 and 5; long frames so bursts stay inside one frame
    gap_lo = 50; gap_hi = 70;
    dmg_seen = 0;
    press();
    wait_until(1, 2, "frame2_timeout");
    melee_hit_raw = 1'b1;
    repeat (40) cycle();
    melee_hit_raw = 1'b0;
    wait_until(1, 5, "frame5_timeout");
    melee_hit_raw = 1'b1;
    repeat (40) cycle();
    melee_hit_raw = 1'b0;
    wait_until(0, -1, "melee_hit_idle_timeout");
    chk("melee_single_dmg", 32'(dmg_seen), 32'd1);
    gap_lo = 3; gap_hi = 8;

    // archer, class flips mid-attack
    char_class = 2'b10; arrow_seen = 0;
    press();
    char_class = 2'b01;
    wait_until(0, -1, "archer_idle_timeout");
    chk("archer_one_arrow", 32'(arrow_seen), 32'd1);

    // held button: exactly one attack
    starts_seen = 0;
    mouse_left = 1'b1;
    cycle();
    wait_until(0, -1, "held_idle_timeout");
    repeat (30) cycle();
    chk("held_one_attack", 32'(starts_seen), 32'd1);
    mouse_left = 1'b0;
    cycle();
    mouse_left = 1'b1;
    cycle();
    cycle();
    chk("repress_busy", 32'(busy), 32'd1);
    mouse_left = 1'b0;
    wait_until(0, -1, "repress_idle_timeout");

    // click in cooldown dropped, class 00 ignored
    press();
    wait_until(3, -1, "cooldown_timeout");
    press();
    wait_until(0, -1, "cool_idle_timeout");
    repeat (20) cycle();
    chk("cool_click_dropped", 32'(busy), 32'd0);
    char_class = 2'b00;
    press();
    repeat (10) cycle();
    chk("class00_ignored", 32'(busy), 32'd0);

    // game inactive mid-swing
    char_class = 2'b01;
    press();
    wait_until(1, 4, "ga_frame4_timeout");
    game_active = 2'b00;
    cycle();
    cycle();
    chk("ga_drop_active", 32'(attack_active), 32'd0);
    chk("ga_drop_anim", 32'(anim_x_offset), 32'd0);
    game_active = 2'b11;
    cycle();

    // asynchronous reset mid-draw
    char_class = 2'b10;
    press();
    wait_until(2, 6, "archer_frame6_timeout");
    arrow_seen = 0;
    rst = 1'b0;
    #1;
    model_reset();
    chk("async_rst_active", 32'(attack_active), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    repeat (3) cycle();
    rst = 1'b1;
    repeat (200) cycle();
    chk("async_rst_no_arrow", 32'(arrow_seen), 32'd0);

    // randomized traffic
    hit_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(11, 0) == 0) mouse_left = ~mouse_left;
      if ($urandom_range(39, 0) == 0) char_class = 2'($urandom_range(3, 0));
      if (game_active == 2'b00) begin
        if ($urandom_range(3, 0) == 0) game_active = 2'($urandom_range(3, 1));
      end else if ($urandom_range(299, 0) == 0) begin
        game_active = 2'b00;
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
